serial_add_ctrl: RTL and testbench

- Bit-serial adder sequencer: adds two WIDTH-bit operands by reusing one 1-bit full-adder cell over WIDTH clock cycles, LSB first.
- Owns the operand shift registers, the carry flip-flop, the bit counter and a start/busy/done handshake.
- Sits between a requester (testbench or CPU datapath control) and the shared full-adder cell; trades latency for area.

---
 rtl/serial_add_ctrl_pkg.sv | 10 +
 rtl/fa_cell.sv | 13 +
 rtl/serial_add_ctrl.sv | 101 ++++++++++
 tb/tb_serial_add_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder sequencer.
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder written as sum-of-products; the only arithmetic in the serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = (a & ~b & ~cin) | (~a & b & ~cin) | (~a & ~b & cin) | (a & b & cin);
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: adds two WIDTH-bit operands LSB first through one shared
// full-adder cell, with a start/busy/done handshake and registered result.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // One extra counter bit keeps WIDTH=1 legal.
  localparam int unsigned     CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e          state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] acc_sh_q;
  logic [WIDTH-1:0] acc_sh_d;
  logic            carry_q;
  logic [CntW-1:0] cnt_q;
  logic            cell_s;
  logic            cell_cout;

  fa_cell u_fa_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (cell_s),
    .cout (cell_cout)
  );

  // New sum bit enters at the MSB so the result lands aligned after WIDTH shifts.
  always_comb begin
    acc_sh_d            = acc_sh_q >> 1;
    acc_sh_d[WIDTH-1]   = cell_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      acc_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            state_q  <= StRun;
            busy     <= 1'b1;
            a_sh_q   <= a;
            b_sh_q   <= b;
            acc_sh_q <= '0;
            carry_q  <= cin;
            cnt_q    <= '0;
          end
        end
        StRun: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          acc_sh_q <= acc_sh_d;
          carry_q  <= cell_cout;
          cnt_q    <= cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            state_q <= StDone;
            done    <= 1'b1;
            sum     <= acc_sh_d;
            cout    <= cell_cout;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8 and WIDTH=1 with hand-computed results.
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst;

  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       cin8;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       cout8;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       cin1;
  logic       busy1;
  logic       done1;
  logic [0:0] sum1;
  logic       cout1;

  int n_vec;
  int n_bad;
  int dcnt8;

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_add_ctrl #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done8) dcnt8++;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; start is accepted on the next rising edge.
  task automatic op8(input logic [7:0] a_v, input logic [7:0] b_v, input logic c_v,
                     input logic [7:0] exp_s, input logic exp_c, input string tag);
    logic [7:0] held;
    int edges;
    int busy_n;
    int changes;
    held   = sum8;
    a8     = a_v;
    b8     = b_v;
    cin8   = c_v;
    start8 = 1'b1;
    edges  = 0;
    busy_n = 0;
    changes = 0;
    do begin
      @(negedge clk);
      start8 = 1'b0;
      a8     = ~a_v;
      b8     = ~b_v;
      edges++;
      if (busy8) busy_n++;
      if (!done8 && sum8 !== held) changes++;
    end while (!done8 && edges < 20);
    check({tag, "_latency"}, edges - 1, 8);
    check({tag, "_busy_cycles"}, busy_n, 9);
    check({tag, "_sum_held"}, changes, 0);
    check({tag, "_sum"}, sum8, exp_s);
    check({tag, "_cout"}, cout8, exp_c);
    @(negedge clk);
    check({tag, "_done_clear"}, done8, 0);
    check({tag, "_idle"}, busy8, 0);
  endtask

  task automatic op1(input logic a_v, input logic b_v, input logic c_v,
                     input logic [1:0] exp, input int idx);
    int edges;
    a1     = a_v;
    b1     = b_v;
    cin1   = c_v;
    start1 = 1'b1;
    edges  = 0;
    do begin
      @(negedge clk);
      start1 = 1'b0;
      edges++;
    end while (!done1 && edges < 10);
    check($sformatf("w1_%0d_latency", idx), edges - 1, 1);
    check($sformatf("w1_%0d_result", idx), {cout1, sum1}, exp);
    @(negedge clk);
  endtask

  logic [1:0] fa_tab [8];
  int d0;
  int edges;
  int done_seen;

  initial begin
    n_vec  = 0;
    n_bad  = 0;
    dcnt8  = 0;
    fa_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    rst    = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_sum8", sum8, 0);
    check("rst_cout8", cout8, 0);
    check("rst_busy1", busy1, 0);
    check("rst_sum1", {cout1, sum1}, 0);
    rst = 1'b0;
    @(negedge clk);

    op8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "add_5a_3c");
    op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ff_01");
    op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "add_ff_ff_c");

    // Start held high with operands changed mid-run.
    d0 = dcnt8;
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    check("cont_busy", busy8, 1);
    a8 = 8'hAA; b8 = 8'h55;
    edges = 1;
    while (!done8 && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    check("cont_latency", edges - 1, 8);
    check("cont_sum", sum8, 8'h30);
    check("cont_cout", cout8, 0);
    @(negedge clk);
    check("cont_ignored_in_done", busy8, 0);
    @(negedge clk);
    check("cont_second_accept", busy8, 1);
    start8 = 1'b0;
    edges = 0;
    while (!done8 && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    check("cont_second_latency", edges, 8);
    check("cont_second_sum", sum8, 8'hFF);
    @(negedge clk);
    #1;
    check("cont_done_count", dcnt8 - d0, 2);
    @(negedge clk);

    // Reset during run cycle 4.
    d0 = dcnt8;
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", busy8, 1);
    rst = 1'b1;
    #1;
    check("abort_busy", busy8, 0);
    check("abort_sum", sum8, 0);
    check("abort_cout", cout8, 0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    check("abort_no_done_cnt", dcnt8 - d0, 0);
    op8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "after_abort");

    op8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "b2b_first");
    op8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "b2b_second");

    for (int i = 0; i < 8; i++) begin
      op1(i[2], i[1], i[0], fa_tab[i], i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
